orthosis_actuator_scheduler: RTL
================================

// Module: orthosis_actuator_scheduler
// PURPOSE
//  Time-shares the orthosis' single high-power actuator rail between four therapy
//  actuators (Servo, Pump, Heat, EMS). Sits between the sensor-decision logic, which
//  raises per-actuator requests, and the actuator drivers, which consume one-hot grants.
//  Enforces a fixed dwell, a dead-time between grants, round-robin fairness and a
//  PPG-driven safety cut-off.
// PARAMETERS
//  ON_CYCLES   8  grant dwell in clk cycles; legal range >=1, <=2**TW
//  GAP_CYCLES  2  dead-time after every grant/abort; 0 = no gap; legal range <=2**TW
//  TW          8  width of the shared dwell/gap down-counter
// PORTS
//  clk          in   1  system clock, rising edge
//  reset        in   1  asynchronous, active-high
//  req          in   4  actuator requests, level: [0]Servo [1]Pump [2]Heat [3]EMS
//  safety       in   1  PPG safety condition, level; overrides everything
//  grant        out  4  one-hot (or zero) registered grant to actuator drivers
//  active_id    out  2  index of current/last granted actuator
//  busy         out  1  1 in ON, GAP or SAFE
//  done         out  1  1-cycle pulse: a grant completed its full dwell
//  abort        out  1  1-cycle pulse: a grant was cut by safety
//  safe_active  out  1  1 while in SAFE
// BEHAVIOUR
//  - Reset (async): state=IDLE, grant=0, active_id=0, busy=done=abort=safe_active=0,
//    timer=0, rr_ptr=3 so bit0 is the first candidate.
//  - All outputs are registered. FSM states: IDLE, ON, GAP, SAFE.
//  - IDLE: safety=1 -> SAFE (no grant, even if req!=0 in the same cycle).
//    Else if req!=0 -> winner = first set bit scanning rr_ptr+1, rr_ptr+2 ... (mod 4);
//    grant<=onehot(winner), active_id<=winner, timer<=ON_CYCLES-1, -> ON.
//    Latency: grant is high on the edge after req is sampled high.
//  - ON: grant held for exactly ON_CYCLES cycles. Deasserting req does not shorten
//    the dwell, and new req bits are ignored.
//    safety=1 -> grant<=0, abort pulse, -> SAFE; rr_ptr is NOT advanced, so the
//    aborted actuator is first in line afterwards.
//    timer==0 -> grant<=0, done pulse, rr_ptr<=active_id, timer<=GAP_CYCLES-1, -> GAP.
//    If GAP_CYCLES==0, go -> IDLE directly.
//  - GAP: grant=0. safety=1 -> SAFE. timer==0 -> IDLE, else timer decrements.
//    Total zero-grant cycles between grants = GAP_CYCLES + 1 (the IDLE arbitration cycle).
//  - SAFE: grant=0, safe_active=1. safety=0 -> timer<=GAP_CYCLES-1, -> GAP
//    (-> IDLE if GAP_CYCLES==0). safe_active drops on the same edge.
//  - Timer is a TW-bit down-counter. It is loaded, never wrapped; reload only on
//    state entry.
//  - done and abort are never high together; each is high for 1 cycle only.
//  - busy = (state != IDLE), registered alongside state.
//  - Reset asserted mid-operation: grant is removed asynchronously; no done/abort pulse.
// TESTING
//  1 req=0001 held: grant=0001 1 cycle after req; high 8 cycles; done pulse on drop;
//    then 3 zero cycles; grant=0001 again.
//  2 req=1111 held: grant sequence 0001,0010,0100,1000,0001; 8 cycles each,
//    3 zero cycles between; active_id 0,1,2,3,0.
//  3 req=0110, safety pulses high during 3rd ON cycle of 0010: grant=0 next edge,
//    abort=1 for 1 cycle, safe_active high while safety is high; after release and
//    3 zero cycles, grant=0010 again (rr_ptr not advanced).
//  4 req=0100 drops after 2 ON cycles: grant stays 0100 for the full 8 cycles, done
//    pulses, no regrant.
//  5 reset asserted mid-ON of 1000: grant=0 without waiting for a clock edge; after
//    release with req=1001, first grant=0001.
//  6 IDLE, safety=1 and req=1111 in the same cycle: no grant, -> SAFE;
//    GAP_CYCLES=0 build: done is followed directly by IDLE, giving 1 zero cycle.

Source files
------------

// File: rtl/orthosis_actuator_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : orthosis_actuator_scheduler
//  Brief    : Round-robin time-share of one actuator rail (Servo/Pump/Heat/EMS)
//             with fixed dwell, dead-time and a PPG safety cut-off.
//  Revision : 1.0 - initial release
// ============================================================================
module orthosis_actuator_scheduler #(
  parameter int ON_CYCLES  = 8,
  parameter int GAP_CYCLES = 2,
  parameter int TW         = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  input  logic       safety,
  output logic [3:0] grant,
  output logic [1:0] active_id,
  output logic       busy,
  output logic       done,
  output logic       abort,
  output logic       safe_active
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_GAP  = 2'd2,
    ST_SAFE = 2'd3
  } state_t;

  localparam logic [TW-1:0] c_on_load  = TW'(ON_CYCLES - 1);
  // The gap load is unused when GAP_CYCLES is zero; clamp it to avoid an underflowed constant.
  localparam logic [TW-1:0] c_gap_load = (GAP_CYCLES == 0) ? '0 : TW'(GAP_CYCLES - 1);

  state_t        r_state;
  logic [TW-1:0] r_timer;
  logic [1:0]    r_rr_ptr;

  logic [1:0]    w_winner;
  logic [1:0]    w_idx;
  logic          w_found;

  // Scan starting one past the last completed grant so every requester gets a turn.
  always_comb begin
    w_winner = r_rr_ptr;
    w_idx    = r_rr_ptr;
    w_found  = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      w_idx = r_rr_ptr + 2'(i);
      if (!w_found && req[w_idx]) begin
        w_winner = w_idx;
        w_found  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_timer     <= '0;
      r_rr_ptr    <= 2'd3;
      grant       <= 4'b0000;
      active_id   <= 2'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
      abort       <= 1'b0;
      safe_active <= 1'b0;
    end else begin
      done  <= 1'b0;
      abort <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (safety) begin
            r_state     <= ST_SAFE;
            busy        <= 1'b1;
            safe_active <= 1'b1;
          end else if (|req) begin
            grant     <= 4'b0001 << w_winner;
            active_id <= w_winner;
            r_timer   <= c_on_load;
            r_state   <= ST_ON;
            busy      <= 1'b1;
          end
        end

        ST_ON: begin
          // rr_ptr stays put on abort so the cut actuator is served first afterwards.
          if (safety) begin
            grant       <= 4'b0000;
            abort       <= 1'b1;
            r_state     <= ST_SAFE;
            safe_active <= 1'b1;
          end else if (r_timer == '0) begin
            grant    <= 4'b0000;
            done     <= 1'b1;
            r_rr_ptr <= active_id;
            if (GAP_CYCLES == 0) begin
              r_state <= ST_IDLE;
              busy    <= 1'b0;
            end else begin
              r_timer <= c_gap_load;
              r_state <= ST_GAP;
            end
          end else begin
            r_timer <= r_timer - 1'b1;
          end
        end

        ST_GAP: begin
          if (safety) begin
            r_state     <= ST_SAFE;
            safe_active <= 1'b1;
          end else if (r_timer == '0) begin
            r_state <= ST_IDLE;
            busy    <= 1'b0;
          end else begin
            r_timer <= r_timer - 1'b1;
          end
        end

        ST_SAFE: begin
          if (!safety) begin
            safe_active <= 1'b0;
            if (GAP_CYCLES == 0) begin
              r_state <= ST_IDLE;
              busy    <= 1'b0;
            end else begin
              r_timer <= c_gap_load;
              r_state <= ST_GAP;
            end
          end
        end

        default: begin
          r_state     <= ST_IDLE;
          grant       <= 4'b0000;
          busy        <= 1'b0;
          safe_active <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
